io_input_fifo: RTL and testbench
================================

# io_input_fifo

Buffered input device for the subleq system. It accepts words from a host-side valid/ready stream and presents them to the memory-mapped I/O decoder through the `in_avail` / `in_read` / `io_in` handshake. It is the producer end of the interface the CPU reads input through: the decoder requests and consumes words, and this block stores and supplies them. It instantiates in the top-level circuit alongside the memory and output device, with its CPU-facing ports wired to the decoder.

## Interface
Parameters:
- `DEPTH`, default 16: number of word entries; power of two, ≥ 2.
- `AW`, default `$clog2(DEPTH)`: pointer width, derived, not overridden.

Ports:
- `clk` input 1: single system clock; all state updates on its rising edge.
- `areset` input 1: reset, synchronous and active-high.
- `host_valid` input 1: host offers `host_data` this cycle.
- `host_ready` output 1: block can accept a word this cycle.
- `host_data` input `WORD_SIZE`: word offered by host.
- `in_avail` output 1: at least one word buffered.
- `in_read` input 1: decoder consumes the head word this cycle.
- `io_in` output `WORD_SIZE`: head word (first-word-fall-through).
- `count` output `AW+1`: number of buffered words, 0..DEPTH.

## Operation
- Storage: circular buffer of `DEPTH` words, read pointer `rd_ptr` and write pointer `wr_ptr` (`AW` bits each, wrap modulo DEPTH), occupancy `count` (`AW+1` bits).
- Push: `host_valid && host_ready` at an edge writes `host_data` at `wr_ptr`, then `wr_ptr+1`, `count+1`.
- Pop: `in_read && in_avail` at an edge advances `rd_ptr+1`, `count-1`. `in_read` while empty is ignored, with no state change and no underflow.
- Simultaneous push and pop: both pointers advance and `count` is unchanged.
- `host_ready = (count != DEPTH)`. `in_avail = (count != 0)`. Both decode combinationally from registered `count`.
- A full buffer with a simultaneous pop still deasserts `host_ready`. There is no same-cycle pass-through slot.
- `io_in` = `mem[rd_ptr]` when `in_avail`, else all zeros. It never shows stale data while empty.
- `in_read` held for k cycles pops min(k, available) words. The decoder drives single-cycle pulses per CPU input load.
- No data loss: a word is dropped only if the host violates valid/ready. `host_data` is ignored when `host_ready` is low.

## Timing
- Reset (`areset` high at an edge): `rd_ptr`, `wr_ptr` and `count` are cleared. Storage contents are not cleared.
- Outputs after reset: `in_avail`=0, `host_ready`=1, `io_in`=0, `count`=0.
- Reset mid-transfer discards all buffered words. A push or pop coinciding with reset is discarded.
- Push-to-visible latency is 1 cycle. A word pushed at edge N gives `in_avail`=1 and `io_in`=word during cycle N+1.
- Pop-to-next-word latency is 1 cycle. After a pop at edge N, `io_in` shows the next word (or 0) in cycle N+1.
- Throughput is one push and one pop per cycle, sustained.
- Wrap-around: pointers wrap from DEPTH-1 to 0 without any bubble.

## Structure
- `WORD_SIZE` comes from `defines.vh`, the existing shared macro.
- Add `` `IO_FIFO_DEPTH `` (16) to `defines.vh` as the top-level default.
- One sub-module, `fifo_ram`, holds the storage:
  - `DEPTH`×`WORD_SIZE` array.
  - One synchronous write port.
  - One asynchronous read port.
- Pointer, count and handshake logic stays in `io_input_fifo`.
- Top-level integration:
  - replace the `io_input` instance with `io_input_fifo`;
  - expose `host_*` as top-level ports.

## Test plan
- **Reset:** assert `areset` for 2 cycles with `host_valid`=1 → `in_avail`=0, `host_ready`=1, `io_in`=0, `count`=0 on release; nothing is captured.
- **Single word:** push 0x002A at edge N → `in_avail`=1 and `io_in`=0x002A in cycle N+1. Pulse `in_read` → `in_avail`=0 and `io_in`=0 next cycle.
- **Fill/full:** push 16 words 1..16 without popping → `count`=16, `host_ready`=0. A 17th `host_valid` with data 99 is ignored. Pop all 16 → values read out in order 1..16.
- **Empty read:** `in_read` pulsed 3 times while empty → `count` stays 0 and no pointer moves. A subsequent push of 7 reads back 7.
- **Simultaneous push/pop:**
  - With `count`=1 (head 5), push 6 and pop in the same cycle → `count`=1 and `io_in`=6.
  - With `count`=16, assert `host_valid` and `in_read` together → pop only, `count`=15.
- **Wrap-around and reset mid-stream:**
  - Stream 40 words with random host/read stalls → output sequence equals input order.
  - Assert reset with 5 words buffered → `count`=0, and the next pushed word is the first read.

Source files
------------

// File: rtl/io_input_fifo_pkg.sv
// Shared types and defaults for the subleq buffered input device.
// Word width and default buffer depth used by the FIFO and its RAM.
package io_input_fifo_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int IO_FIFO_DEPTH = 16;

    typedef logic [WORD_SIZE-1:0] word_t;

endpackage

// File: rtl/io_input_fifo_if.sv
// Host stream and CPU decoder handshake bundle for io_input_fifo.
// The master is the host/decoder side, the slave is the FIFO.
interface io_input_fifo_if
    import io_input_fifo_pkg::*;
#(
    parameter int DEPTH = IO_FIFO_DEPTH
) ();

    localparam int AW = $clog2(DEPTH);

    logic          host_valid;
    logic          host_ready;
    word_t         host_data;
    logic          in_avail;
    logic          in_read;
    word_t         io_in;
    logic [AW:0]   count;

    modport master (
        output host_valid,
        output host_data,
        output in_read,
        input  host_ready,
        input  in_avail,
        input  io_in,
        input  count
    );

    modport slave (
        input  host_valid,
        input  host_data,
        input  in_read,
        output host_ready,
        output in_avail,
        output io_in,
        output count
    );

endinterface

// File: rtl/io_input_fifo_ram.sv
// Word storage for io_input_fifo: one synchronous write port and
// one asynchronous read port so the head word falls through.
module fifo_ram
    import io_input_fifo_pkg::*;
#(
    parameter int DEPTH = IO_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);

    word_t mem [DEPTH];

    // Capture the pushed word; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/io_input_fifo.sv
// Buffered input device: host valid/ready stream in, decoder
// in_avail/in_read/io_in out, first-word-fall-through.
module io_input_fifo
    import io_input_fifo_pkg::*;
#(
    parameter int DEPTH = IO_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            areset,
    io_input_fifo_if.slave  bus
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    logic          host_ready, in_avail;
    word_t         rd_data;

    // Handshakes decode from registered count only, so a full
    // buffer refuses a push even when a pop happens the same cycle.
    assign host_ready = (count_q != CNT_FULL);
    assign in_avail   = (count_q != '0);
    assign push       = bus.host_valid && host_ready;
    assign pop        = bus.in_read && in_avail;

    // Next pointer and occupancy from the push/pop pair.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset drops everything buffered.
    always_ff @(posedge clk) begin
        if (areset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push && !areset),
        .waddr (wr_ptr_q),
        .wdata (bus.host_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign bus.host_ready = host_ready;
    assign bus.in_avail   = in_avail;
    assign bus.count      = count_q;
    assign bus.io_in      = in_avail ? rd_data : '0;

endmodule

// File: tb/tb_io_input_fifo.sv
// Directed bench for io_input_fifo: vector table plus hand
// sequences for reset, full, simultaneous and streaming cases.
module tb_io_input_fifo;
    import io_input_fifo_pkg::*;

    localparam int DEPTH = 16;

    typedef struct {
        logic  valid;
        word_t data;
        logic  read;
        logic  e_avail;
        logic  e_ready;
        word_t e_io;
        int    e_count;
    } vec_t;

    logic clk = 1'b0;
    logic areset;
    int   n_tests = 0;
    int   n_fail  = 0;

    io_input_fifo_if #(.DEPTH(DEPTH)) bus ();

    io_input_fifo #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.host_valid = 1'b0;
        bus.host_data  = '0;
        bus.in_read    = 1'b0;
    endtask

    task automatic push(input word_t d);
        bus.host_valid = 1'b1;
        bus.host_data  = d;
        bus.in_read    = 1'b0;
        tick();
        idle();
    endtask

    task automatic check_all(input string name, input logic av,
                             input logic rdy, input word_t io,
                             input int cnt);
        check({name, ".avail"}, int'(bus.in_avail), int'(av));
        check({name, ".ready"}, int'(bus.host_ready), int'(rdy));
        check({name, ".io_in"}, int'(bus.io_in), int'(io));
        check({name, ".count"}, int'(bus.count), cnt);
    endtask

    vec_t vecs [10];

    initial begin
        word_t q [$];
        int    sent;
        int    got;
        int    cyc;
        logic  v;
        logic  r;
        logic  do_push;
        logic  do_pop;

        vecs[0] = '{1'b1, 16'h002A, 1'b0, 1'b1, 1'b1, 16'h002A, 1};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        vecs[5] = '{1'b1, 16'h0007, 1'b0, 1'b1, 1'b1, 16'h0007, 1};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        vecs[7] = '{1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0005, 1};
        vecs[8] = '{1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 16'h0006, 1};
        vecs[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 0};

        // Reset with host pushing: nothing is captured.
        idle();
        areset         = 1'b1;
        bus.host_valid = 1'b1;
        bus.host_data  = 16'h0055;
        tick();
        tick();
        areset = 1'b0;
        idle();
        check_all("reset", 1'b0, 1'b1, 16'h0000, 0);
        tick();
        check_all("reset_idle", 1'b0, 1'b1, 16'h0000, 0);

        // Single word, empty reads, push/pop overlap.
        foreach (vecs[i]) begin
            bus.host_valid = vecs[i].valid;
            bus.host_data  = vecs[i].data;
            bus.in_read    = vecs[i].read;
            tick();
            idle();
            check_all($sformatf("vec%0d", i), vecs[i].e_avail,
                      vecs[i].e_ready, vecs[i].e_io, vecs[i].e_count);
        end

        // Fill to full.
        for (int i = 1; i <= DEPTH; i++) begin
            push(word_t'(i));
        end
        check_all("full", 1'b1, 1'b0, 16'h0001, DEPTH);
        push(16'd99);
        check_all("full_ignore", 1'b1, 1'b0, 16'h0001, DEPTH);

        // Full with push and pop together: pop only.
        bus.host_valid = 1'b1;
        bus.host_data  = 16'd77;
        bus.in_read    = 1'b1;
        tick();
        idle();
        check_all("full_pushpop", 1'b1, 1'b1, 16'h0002, DEPTH - 1);

        // Drain and verify order 2..16.
        for (int i = 2; i <= DEPTH; i++) begin
            check($sformatf("drain%0d", i), int'(bus.io_in), i);
            bus.in_read = 1'b1;
            tick();
            idle();
        end
        check_all("drained", 1'b0, 1'b1, 16'h0000, 0);

        // Stream 40 words with random stalls through the wrap.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((got < 40) && (cyc < 2000)) begin
            v = (sent < 40) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            bus.host_valid = v;
            bus.host_data  = word_t'(16'h0100 + sent);
            bus.in_read    = r;
            #1;
            if (int'(bus.count) != q.size()) begin
                check("stream.count", int'(bus.count), q.size());
            end
            if (q.size() > 0 && bus.io_in !== q[0]) begin
                check("stream.io_in", int'(bus.io_in), int'(q[0]));
            end
            do_push = v && (q.size() < DEPTH);
            do_pop  = r && (q.size() > 0);
            if (do_pop) begin
                check($sformatf("stream.w%0d", got), int'(bus.io_in),
                      16'h0100 + got);
                void'(q.pop_front());
                got++;
            end
            if (do_push) begin
                q.push_back(word_t'(16'h0100 + sent));
                sent++;
            end
            tick();
            cyc++;
        end
        idle();
        check("stream.done", got, 40);
        #1;
        check_all("stream_end", 1'b0, 1'b1, 16'h0000, 0);

        // Reset mid-stream with 5 words buffered and a push/pop.
        for (int i = 0; i < 5; i++) begin
            push(word_t'(16'h0010 + i));
        end
        check("mid.count", int'(bus.count), 5);
        areset         = 1'b1;
        bus.host_valid = 1'b1;
        bus.host_data  = 16'h00EE;
        bus.in_read    = 1'b1;
        tick();
        areset = 1'b0;
        idle();
        check_all("mid_reset", 1'b0, 1'b1, 16'h0000, 0);
        push(16'h0033);
        check_all("after_reset", 1'b1, 1'b1, 16'h0033, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
